// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing for the 32x32 ram and the FIFO controller that fronts it.
// Also holds the pointer/count types and the pointer-increment helper.
package ram_fifo_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [DATA_W-1:0] word_t;

    // Pointers wrap modulo DEPTH simply by overflowing ADDR_W bits.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_fifo_ptr_cnt.sv
// Occupancy counter with registered full/empty flags.
// inc and dec are never asserted together by the controller.
module fifo_ptr_cnt
    import ram_fifo_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    input  logic dec,
    output cnt_t count,
    output logic full,
    output logic empty
);

    cnt_t count_r;
    cnt_t count_nxt_s;
    logic full_r;
    logic empty_r;

    // Next occupancy; clear wins over any access.
    always_comb begin
        count_nxt_s = count_r;
        if (clear) begin
            count_nxt_s = {(ADDR_W+1){1'b0}};
        end else if (inc && !dec) begin
            count_nxt_s = count_r + cnt_t'(1);
        end else if (dec && !inc) begin
            count_nxt_s = count_r - cnt_t'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Flags are registered from the next count so they line up with count_r.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {(ADDR_W+1){1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == cnt_t'(DEPTH));
            empty_r <= (count_nxt_s == {(ADDR_W+1){1'b0}});
        end
    end

    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller owning the single-port ram pins; one ram access per cycle,
// pop wins over push when both are requested.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_valid,
    output logic              pop_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    ptr_t  wr_ptr_r;
    ptr_t  rd_ptr_r;
    word_t rd_data_r;
    logic  rd_valid_r;
    logic  full_s;
    logic  empty_s;
    logic  pop_fire_s;
    logic  push_fire_s;

    fifo_ptr_cnt u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (push_fire_s),
        .dec     (pop_fire_s),
        .count   (count),
        .full    (full_s),
        .empty   (empty_s)
    );

    // reset_n gates push_ready so the ram goes idle the instant reset asserts.
    assign pop_ready   = !empty_s && !clear;
    assign push_ready  = reset_n && !full_s && !clear && !(pop_valid && pop_ready);
    assign pop_fire_s  = pop_valid && pop_ready;
    assign push_fire_s = push_valid && push_ready;

    // Ram port drive; idle cycles park every pin at zero.
    always_comb begin
        ram_cen  = 1'b0;
        ram_wen  = 1'b0;
        ram_addr = {ADDR_W{1'b0}};
        ram_din  = {DATA_W{1'b0}};
        if (pop_fire_s) begin
            ram_cen  = 1'b1;
            ram_addr = rd_ptr_r;
        end else if (push_fire_s) begin
            ram_cen  = 1'b1;
            ram_wen  = 1'b1;
            ram_addr = wr_ptr_r;
            ram_din  = push_data;
        end else begin
            ram_cen  = 1'b0;
        end
    end

    // Read/write pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
        end else begin
            if (pop_fire_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (push_fire_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
        end
    end

    // Read data capture; rd_data holds across idle and clear cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (clear) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= pop_fire_s;
            if (pop_fire_s) begin
                rd_data_r <= ram_dout;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign full     = full_s;
    assign empty    = empty_s;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 32x32 single-port ram and a
// queue-based FIFO model feeding a read-data scoreboard.
module tb_ram_fifo_ctrl;
    import ram_fifo_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              clear;
    logic              push_valid;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop_valid;
    logic              pop_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              ram_cen;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic [DATA_W-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .full(full), .empty(empty),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    assign ram_dout = (ram_cen && !ram_wen) ? mem[ram_addr] : 32'd0;

    always @(posedge clk) begin
        if (ram_cen && ram_wen) mem[ram_addr] <= ram_din;
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] m_wr = 5'd0;
    logic [ADDR_W-1:0] m_rd = 5'd0;
    logic [DATA_W-1:0] last_rd = 32'd0;
    logic obs_push_rdy, obs_pop_rdy, obs_rv;

    typedef struct {
        logic        pv;
        logic [31:0] pd;
        logic        popv;
        logic        clr;
        logic [5:0]  ecnt;
        logic        eprdy;
        logic        epoprdy;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive after negedge, check comb outputs, update model, check after posedge.
    task automatic step(input logic pv, input logic [31:0] pd, input logic popv, input logic clr);
        logic exp_pop_rdy, exp_push_rdy, pop_f, push_f;
        logic [38:0] exp_ram;
        push_valid = pv; push_data = pd; pop_valid = popv; clear = clr;
        #1;
        exp_pop_rdy  = (m_q.size() != 0) && !clr;
        exp_push_rdy = (m_q.size() != DEPTH) && !clr && !(popv && exp_pop_rdy);
        obs_pop_rdy  = pop_ready;
        obs_push_rdy = push_ready;
        chk("pop_ready", {63'd0, pop_ready}, {63'd0, exp_pop_rdy});
        chk("push_ready", {63'd0, push_ready}, {63'd0, exp_push_rdy});
        pop_f  = popv && exp_pop_rdy;
        push_f = pv && exp_push_rdy;
        exp_ram = {pop_f | push_f, push_f,
                   pop_f ? m_rd : (push_f ? m_wr : 5'd0),
                   push_f ? pd : 32'd0};
        chk("ram_drive", {25'd0, ram_cen, ram_wen, ram_addr, ram_din}, {25'd0, exp_ram});
        if (clr) begin
            m_q.delete(); m_wr = 5'd0; m_rd = 5'd0;
        end else if (pop_f) begin
            exp_q.push_back(m_q.pop_front()); m_rd = m_rd + 5'd1;
        end else if (push_f) begin
            m_q.push_back(pd); m_wr = m_wr + 5'd1;
        end
        @(posedge clk); #1;
        obs_rv = rd_valid;
        chk("rd_valid", {63'd0, rd_valid}, {63'd0, pop_f});
        if (pop_f) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                last_rd = exp_q.pop_front();
            end
        end
        chk("rd_data", {32'd0, rd_data}, {32'd0, last_rd});
        chk("count", {58'd0, count}, 64'(m_q.size()));
        chk("full_empty", {62'd0, full, empty}, {62'd0, m_q.size() == DEPTH, m_q.size() == 0});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        tbl[0]  = '{1'b1, 32'h31, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 32'h32, 1'b0, 1'b0, 6'd2, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 6'd3, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 32'h05, 1'b1, 1'b0, 6'd2, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 32'h05, 1'b0, 1'b0, 6'd3, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 6'd2, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 6'd1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 32'h07, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 32'h08, 1'b0, 1'b0, 6'd2, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 32'h09, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 32'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 32'h00, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0};

        reset_n = 1'b0; clear = 1'b0; push_valid = 1'b0; push_data = 32'd0; pop_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_count", {58'd0, count}, 64'd0);
        chk("reset_flags", {62'd0, full, empty}, 64'd1);
        chk("reset_rd", {31'd0, rd_valid, rd_data}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: fill to full, then an ignored 33rd push
        for (int i = 1; i <= 32; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        chk("full_after_fill", {63'd0, full}, 64'd1);
        step(1'b1, 32'd99, 1'b0, 1'b0);

        // 2: drain in order
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            if (obs_rv) pulses++;
        end
        chk("drain_pulses", 64'(pulses), 64'd32);
        step(1'b0, 32'd0, 1'b0, 1'b0);

        // 3 and 5: shared push/pop cycle, clear flush
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].pv, tbl[i].pd, tbl[i].popv, tbl[i].clr);
            chk("tbl_count", {58'd0, count}, {58'd0, tbl[i].ecnt});
            chk("tbl_ready", {62'd0, obs_push_rdy, obs_pop_rdy}, {62'd0, tbl[i].eprdy, tbl[i].epoprdy});
        end

        // 4: pointer wrap
        for (int i = 0; i < 20; i++) step(1'b1, 32'(200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            chk("wrap_data", {32'd0, rd_data}, 64'(100 + i));
        end

        // 6: async reset mid-cycle with count=10
        for (int i = 0; i < 11; i++) step(1'b1, 32'(300 + i), 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("pre_reset_count", {58'd0, count}, 64'd10);
        push_valid = 1'b1; push_data = 32'hdead;
        #2 reset_n = 1'b0;
        #1;
        chk("async_count", {58'd0, count}, 64'd0);
        chk("async_rd", {31'd0, rd_valid, rd_data}, 64'd0);
        chk("async_ram_idle", {62'd0, ram_cen, push_ready}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_q.delete(); exp_q.delete(); m_wr = 5'd0; m_rd = 5'd0; last_rd = 32'd0;
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
